mult_div_unit: RTL



---
 rtl/mult_div_unit.sv | 115 +++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit feeding the HI/LO registers.
// One shift-add (mult) or restoring-divide step per clock, then a sign-fix cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic               op_r;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      counter;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   rem_next;
  logic               q_bit;

  // acc holds {partial product, unconsumed multiplier} for mult and
  // {partial remainder, dividend/quotient bits} for div.
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_a : {WIDTH{1'b0}})};
    shifted  = acc[2*WIDTH-1:WIDTH-1];
    diff     = shifted - {1'b0, mag_b};
    q_bit    = (shifted >= {1'b0, mag_b});
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    if (op_r)
      acc_next = {rem_next, acc[WIDTH-2:0], q_bit};
    else
      acc_next = {add_sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      counter  <= '0;
      op_r     <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      acc      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r     <= op;
            sign_a   <= a[WIDTH-1];
            sign_b   <= b[WIDTH-1];
            mag_a    <= a[WIDTH-1] ? -a : a;
            mag_b    <= b[WIDTH-1] ? -b : b;
            div_zero <= op && (b == '0);
            if (op && (b == '0)) begin
              done <= 1'b1;
            end else begin
              state   <= CALC;
              busy    <= 1'b1;
              counter <= '0;
              // Seed the low half with the operand consumed bit by bit.
              if (op)
                acc <= {{WIDTH{1'b0}}, (a[WIDTH-1] ? -a : a)};
              else
                acc <= {{WIDTH{1'b0}}, (b[WIDTH-1] ? -b : b)};
            end
          end
        end
        CALC: begin
          acc     <= acc_next;
          counter <= counter + 1'b1;
          if (counter == CW'(WIDTH - 1))
            state <= FIX;
        end
        FIX: begin
          if (op_r) begin
            lo <= (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            hi <= sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
          end else begin
            {hi, lo} <= (sign_a ^ sign_b) ? -acc : acc;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
